// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: collects reset requests, holds every domain in reset, then
// releases the domains one at a time and blocks new requests for a holdoff window.
`timescale 1ns/1ps

module rst_seq_ctrl #(
    parameter int N_DOM     = 4,
    parameter int PULSE_LEN = 16,
    parameter int STAGE_GAP = 8,
    parameter int HOLDOFF   = 32
) (
    input  logic             clk,
    input  logic             SYSTEM_RST,
    input  logic             WD_RES,
    input  logic             Flag_OF,
    input  logic             time_clear,
    input  logic             sw_req,
    output logic [N_DOM-1:0] rst_n,
    output logic             busy,
    output logic [4:0]       cause,
    output logic             seq_done,
    output logic [7:0]       rst_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_RELEASE,
        ST_HOLDOFF
    } state_t;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LAST   = 8'(STAGE_GAP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLDOFF - 1);
    localparam logic [3:0] DOM_LAST   = 4'(N_DOM - 1);

    state_t           state;
    logic [7:0]       cnt;
    logic [3:0]       dom;
    logic [4:0]       pend;

    logic [4:0]       src;
    logic             req;
    logic [N_DOM-1:0] next_mask;
    logic [7:0]       count_next;

    // src bit 0 is the power-on slot, which no request input can set.
    always_comb begin
        src        = {sw_req, ~time_clear, Flag_OF, WD_RES, 1'b0};
        req        = |src;
        next_mask  = (rst_n << 1) | N_DOM'(1);
        count_next = (rst_count == 8'hFF) ? rst_count : rst_count + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (SYSTEM_RST) begin
            state     <= ST_ASSERT;
            cnt       <= 8'd0;
            dom       <= 4'd0;
            pend      <= 5'd0;
            rst_n     <= '0;
            busy      <= 1'b1;
            cause     <= 5'b00001;
            seq_done  <= 1'b0;
            rst_count <= 8'd0;
        end else begin
            seq_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        state     <= ST_ASSERT;
                        cnt       <= 8'd0;
                        cause     <= src;
                        rst_n     <= '0;
                        busy      <= 1'b1;
                        rst_count <= count_next;
                        pend      <= 5'd0;
                    end
                end

                ST_ASSERT: begin
                    if (req) begin
                        cnt   <= 8'd0;
                        cause <= cause | src;
                    end else if (cnt == PULSE_LAST) begin
                        cnt   <= 8'd0;
                        dom   <= 4'd1;
                        rst_n <= N_DOM'(1);
                        if (N_DOM == 1) begin
                            state    <= ST_HOLDOFF;
                            seq_done <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                ST_RELEASE: begin
                    if (req) begin
                        state <= ST_ASSERT;
                        cnt   <= 8'd0;
                        rst_n <= '0;
                        cause <= cause | src;
                    end else if (cnt == GAP_LAST) begin
                        cnt   <= 8'd0;
                        dom   <= dom + 4'd1;
                        rst_n <= next_mask;
                        if (dom == DOM_LAST) begin
                            state    <= ST_HOLDOFF;
                            seq_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                ST_HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= 8'd0;
                        // Deferred requests and one arriving on the final cycle start together.
                        if ((pend != 5'd0) || req) begin
                            state     <= ST_ASSERT;
                            cause     <= pend | src;
                            rst_n     <= '0;
                            rst_count <= count_next;
                            pend      <= 5'd0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt  <= cnt + 8'd1;
                        pend <= pend | src;
                    end
                end

                default: state <= ST_ASSERT;
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a phase/time model checked every cycle, plus directed
// scenarios with hand-computed cycle offsets and register values.
`timescale 1ns/1ps

module tb_rst_seq_ctrl;

    localparam int N  = 4;
    localparam int PL = 16;
    localparam int SG = 8;
    localparam int HO = 32;

    logic         clk = 1'b0;
    logic         SYSTEM_RST = 1'b1;
    logic         WD_RES = 1'b0;
    logic         Flag_OF = 1'b0;
    logic         time_clear = 1'b1;
    logic         sw_req = 1'b0;
    logic [N-1:0] rst_n;
    logic         busy;
    logic [4:0]   cause;
    logic         seq_done;
    logic [7:0]   rst_count;

    int n_chk = 0;
    int n_fail = 0;

    rst_seq_ctrl #(
        .N_DOM(N), .PULSE_LEN(PL), .STAGE_GAP(SG), .HOLDOFF(HO)
    ) dut (
        .clk(clk), .SYSTEM_RST(SYSTEM_RST), .WD_RES(WD_RES), .Flag_OF(Flag_OF),
        .time_clear(time_clear), .sw_req(sw_req), .rst_n(rst_n), .busy(busy),
        .cause(cause), .seq_done(seq_done), .rst_count(rst_count)
    );

    // Clock, cycle index and the inputs each edge actually saw.
    always #5 clk = ~clk;

    int         cyc = 0;
    logic [4:0] smp = 5'd0;
    logic       smp_valid = 1'b0;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        smp       <= {SYSTEM_RST, WD_RES, Flag_OF, time_clear, sw_req};
        smp_valid <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: ph 0 idle, 1 held in reset, 2 staged release, 3 holdoff.
    // q = quiet edges while held, t = cycles since domain 0 released, h = cycles since seq_done.
    int         ph = 1, q = 0, t = 0, h = 0, m_count = 0;
    logic [4:0] m_cause = 5'b00001, m_pend = 5'd0;

    task automatic m_start(input logic [4:0] s);
        ph      = 1;
        q       = 0;
        m_cause = {s[4:1], 1'b0};
        m_pend  = 5'd0;
        if (m_count < 255) m_count++;
    endtask

    task automatic model_step(input logic [4:0] in);
        logic [4:0] s;
        s = {in[0], ~in[1], in[2], in[3], 1'b0};
        if (in[4]) begin
            ph = 1; q = 0; m_cause = 5'b00001; m_pend = 5'd0; m_count = 0;
        end else begin
            case (ph)
                0: if (s != 5'd0) m_start(s);
                1: begin
                    if (s != 5'd0) begin
                        q = 0;
                        m_cause = m_cause | s;
                    end else begin
                        q++;
                        if (q == PL) begin
                            if (N == 1) begin ph = 3; h = 0; end
                            else begin ph = 2; t = 0; end
                        end
                    end
                end
                2: begin
                    if (s != 5'd0) begin
                        ph = 1; q = 0;
                        m_cause = m_cause | s;
                    end else begin
                        t++;
                        if (t == SG * (N - 1)) begin ph = 3; h = 0; end
                    end
                end
                default: begin
                    h++;
                    if (h == HO) begin
                        if ((m_pend | s) != 5'd0) m_start(m_pend | s);
                        else ph = 0;
                    end else begin
                        m_pend = m_pend | s;
                    end
                end
            endcase
        end
    endtask

    // Per-cycle compare plus seq_done / domain-0 release observers.
    int   done_cnt = 0, done_cyc = 0, rise_cyc = 0;
    logic prev0 = 1'b0;
    initial begin
        logic [N-1:0] e_rst_n;
        logic [18:0]  e_all, g_all;
        forever begin
            @(negedge clk);
            if (smp_valid) begin
                model_step(smp);
                if (ph == 1) e_rst_n = '0;
                else if (ph == 2) e_rst_n = N'((1 << (t / SG + 1)) - 1);
                else e_rst_n = '1;
                e_all = {e_rst_n, 1'(ph != 0), m_cause, 1'(ph == 3 && h == 0), 8'(m_count)};
                g_all = {rst_n, busy, cause, seq_done, rst_count};
                check("cycle_outputs", 32'(g_all), 32'(e_all));
                if (seq_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
                if (rst_n[0] === 1'b1 && prev0 === 1'b0) rise_cyc = cyc;
                prev0 = rst_n[0];
            end
        end
    end

    // Driver tasks.
    task automatic pulse(input int which, output int e);
        @(posedge clk); #2;
        if (which == 0) WD_RES = 1'b1;
        else sw_req = 1'b1;
        e = cyc + 1;
        @(posedge clk); #2;
        WD_RES = 1'b0;
        sw_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int  start;
        bit  hit;
        start = done_cnt;
        hit   = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk); #1;
            if (done_cnt != start) hit = 1'b1;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: no seq_done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk); #1;
            if (busy === 1'b0) hit = 1'b1;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: busy still %b after %0d cycles", name, busy, budget);
        end
    endtask

    task automatic wait_mask(input string name, input logic [N-1:0] m, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk); #1;
            if (rst_n === m) hit = 1'b1;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: rst_n %b never reached %b", name, rst_n, m);
        end
    endtask

    task automatic wait_cyc(input int c);
        for (int i = 0; i < 200 && cyc < c; i++) begin
            @(negedge clk); #1;
        end
    endtask

    initial begin
        int base, e, d, idle_cyc;

        // Power-on: reset values, then the unrequested sequence.
        repeat (3) @(negedge clk);
        #1;
        check("por_rst_n", 32'(rst_n), 32'h0);
        check("por_busy", 32'(busy), 32'h1);
        check("por_cause", 32'(cause), 32'h01);
        check("por_seq_done", 32'(seq_done), 32'h0);
        check("por_rst_count", 32'(rst_count), 32'h0);
        @(posedge clk); #2;
        SYSTEM_RST = 1'b0;
        base = cyc;
        wait_done("por_done", 100);
        check("por_rise_offset", 32'(rise_cyc - base), 32'd16);
        check("por_done_offset", 32'(done_cyc - base), 32'd40);
        wait_idle("por_idle", 100);
        idle_cyc = cyc;
        check("por_idle_offset", 32'(idle_cyc - base), 32'd72);
        check("por_cause_after", 32'(cause), 32'h01);
        check("por_count_after", 32'(rst_count), 32'h0);

        // Single-cycle watchdog request from idle.
        pulse(0, e);
        wait_done("wd_done", 100);
        check("wd_cause", 32'(cause), 32'h02);
        check("wd_count", 32'(rst_count), 32'h1);
        check("wd_rise_offset", 32'(rise_cyc - e), 32'd16);
        check("wd_done_offset", 32'(done_cyc - e), 32'd40);
        wait_idle("wd_idle", 100);

        // Overflow request held for 40 cycles: release counts from its fall.
        @(posedge clk); #2;
        Flag_OF = 1'b1;
        e = cyc + 1;
        repeat (40) @(posedge clk);
        #2;
        Flag_OF = 1'b0;
        wait_done("of_done", 100);
        check("of_rise_offset", 32'(rise_cyc - e), 32'd55);
        check("of_cause", 32'(cause), 32'h04);
        check("of_count", 32'(rst_count), 32'h2);
        wait_idle("of_idle", 100);

        // time_clear low while rst_n = 0011 aborts the release.
        pulse(0, e);
        wait_mask("tc_reach_0011", 4'b0011, 100);
        time_clear = 1'b0;
        e = cyc + 1;
        @(posedge clk); #2;
        time_clear = 1'b1;
        @(negedge clk); #1;
        check("tc_abort_rst_n", 32'(rst_n), 32'h0);
        check("tc_abort_cause", 32'(cause), 32'h0A);
        check("tc_abort_count", 32'(rst_count), 32'h3);
        check("tc_abort_no_done", 32'(seq_done), 32'h0);
        wait_done("tc_done", 100);
        check("tc_done_offset", 32'(done_cyc - e), 32'd40);

        // Software request deferred during holdoff.
        d = done_cyc;
        repeat (10) @(posedge clk);
        #2;
        sw_req = 1'b1;
        @(posedge clk); #2;
        sw_req = 1'b0;
        wait_cyc(d + 31);
        check("hold_rst_n_kept", 32'(rst_n), 32'hF);
        check("hold_busy_kept", 32'(busy), 32'h1);
        check("hold_cause_kept", 32'(cause), 32'h0A);
        @(negedge clk); #1;
        check("hold_restart_rst_n", 32'(rst_n), 32'h0);
        check("hold_restart_cause", 32'(cause), 32'h10);
        check("hold_restart_count", 32'(rst_count), 32'h4);
        wait_done("hold_done", 100);
        check("hold_done_offset", 32'(done_cyc - (d + 32)), 32'd40);
        wait_idle("hold_idle", 100);

        // 300 back-to-back requests saturate the counter.
        for (int i = 0; i < 300; i++) begin
            pulse(1, e);
            wait_done("b2b_done", 200);
        end
        check("b2b_count_sat", 32'(rst_count), 32'hFF);

        // Block reset during release overrides a simultaneous request.
        pulse(1, e);
        wait_mask("sysrst_reach_0011", 4'b0011, 200);
        SYSTEM_RST = 1'b1;
        sw_req = 1'b1;
        @(negedge clk); #1;
        check("sysrst_rst_n", 32'(rst_n), 32'h0);
        check("sysrst_busy", 32'(busy), 32'h1);
        check("sysrst_cause", 32'(cause), 32'h01);
        check("sysrst_seq_done", 32'(seq_done), 32'h0);
        check("sysrst_count", 32'(rst_count), 32'h0);
        @(posedge clk); #2;
        SYSTEM_RST = 1'b0;
        sw_req = 1'b0;
        base = cyc;
        wait_done("sysrst_por_done", 100);
        check("sysrst_done_offset", 32'(done_cyc - base), 32'd40);
        wait_idle("sysrst_idle", 100);
        check("sysrst_count_after", 32'(rst_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): N_DOM, 4, number of reset domains (1..8).
REQ-002 PULSE_LEN, 16, cycles all domains stay in reset after the last request (1..255).
REQ-003 STAGE_GAP, 8, cycles between successive domain releases (1..255).
REQ-004 HOLDOFF, 32, cycles after sequence completion during which new requests are deferred (1..255).
REQ-005 Ports SHALL be (name, direction, width, meaning): clk, in, 1, sole clock, rising edge.
REQ-006 SYSTEM_RST, in, 1, synchronous, active-high block reset.
REQ-007 WD_RES, in, 1, watchdog reset request, active-high level.
REQ-008 Flag_OF, in, 1, overflow reset request, active-high level.
REQ-009 time_clear, in, 1, time-clear reset request, active-low level.
REQ-010 sw_req, in, 1, software reset request, active-high level.
REQ-011 rst_n, out, N_DOM, per-domain reset, active-low (0 = domain held in reset).
REQ-012 busy, out, 1, high while any sequence or holdoff is in progress.
REQ-013 cause, out, 5, latched request sources {sw, tc, of, wd, por}, bit 0 = por.
REQ-014 seq_done, out, 1, one-cycle pulse when the last domain is released.
REQ-015 rst_count, out, 8, number of non-POR sequences started, saturating.

Function
REQ-016 req SHALL be defined as WD_RES | Flag_OF | !time_clear | sw_req, sampled on every rising clk edge.
REQ-017 FSM states SHALL be IDLE, ASSERT, RELEASE, HOLDOFF; all outputs registered.
REQ-018 One 8-bit cycle counter and a domain index SHALL be used; no arithmetic wider than 8 bits.
REQ-019 IDLE: rst_n all 1, busy 0; on req go to ASSERT, clear counter, load cause with {sw,tc,of,wd,0}, rst_n all 0, rst_count += 1 saturating at 255.
REQ-020 ASSERT: rst_n all 0; counter increments each cycle; any req restarts counter at 0 and ORs its sources into cause.
REQ-021 ASSERT exits to RELEASE when the counter reaches PULSE_LEN-1 with req low; rst_n[0] goes 1 on that edge.
REQ-022 RELEASE: rst_n[k] SHALL go 1 exactly STAGE_GAP*k cycles after rst_n[0]; release order strictly 0..N_DOM-1.
REQ-023 seq_done SHALL pulse high in the same cycle rst_n[N_DOM-1] goes 1; with N_DOM=1 this is the ASSERT->RELEASE edge.
REQ-024 req during RELEASE SHALL abort: all rst_n to 0 on the next edge, return to ASSERT, counter 0, sources ORed into cause, rst_count unchanged, no seq_done.
REQ-025 HOLDOFF: lasts HOLDOFF cycles after seq_done, busy stays 1; req during HOLDOFF sets a pending flag and has no other effect.
REQ-026 At HOLDOFF end: pending set or req high -> ASSERT as in REQ-019 (cause reloaded from pending sources ORed with current req); else IDLE.
REQ-027 Pending flag SHALL record source bits (5-bit OR); cleared on entry to ASSERT.
REQ-028 cause SHALL hold its value in IDLE until the next sequence starts.

Reset
REQ-029 While SYSTEM_RST=1: rst_n all 0, busy 1, cause 5'b00001, seq_done 0, rst_count 0, pending 0, state ASSERT, counter 0.
REQ-030 After SYSTEM_RST deasserts, a full power-on sequence (ASSERT -> RELEASE -> HOLDOFF) SHALL run without any request; rst_count not incremented.
REQ-031 SYSTEM_RST asserted mid-sequence SHALL restore REQ-029 values on the next edge, overriding all requests.

Verification
REQ-032 POR: SYSTEM_RST 1 -> 0, no requests -> rst_n=0000 for 16 cycles, then bits rise at +0/+8/+16/+24, seq_done with bit 3, busy falls 32 cycles later, cause=00001, rst_count=0.
REQ-033 WD pulse in IDLE, 1 cycle -> cause=00010, rst_count=1, rst_n=0000 for 16 cycles, then staged release as above.
REQ-034 Flag_OF held 40 cycles -> rst_n stays 0000 until 16 cycles after Flag_OF falls; cause=00100.
REQ-035 time_clear low at rst_n=0011 (RELEASE) -> rst_n=0000 next cycle, cause gains bit 3, no seq_done, new full sequence.
REQ-036 sw_req 1-cycle pulse 10 cycles into HOLDOFF -> no output change until holdoff expires, then new sequence with cause=10000, rst_count +1.
REQ-037 300 back-to-back request sequences -> rst_count saturates at 255; SYSTEM_RST mid-RELEASE -> REQ-029 values next edge.
